// File: rtl/mem_pkg.sv
// Shared types and constants for the memory stage.
package mem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int TIMEOUT_DEF = 16;
    localparam int CNT_W       = 8;

    typedef struct packed {
        logic        dmem_we;
        logic        reg_we;
        logic        swd;
        logic [4:0]  wra;
        logic [31:0] alu_out;
        logic [31:0] store_data;
    } stage_t;

    typedef struct packed {
        logic        reg_we;
        logic [4:0]  wra;
        logic [31:0] wd;
    } wb_t;

    localparam wb_t BUBBLE = '0;

    function automatic logic is_access(input stage_t s);
        return s.dmem_we | (s.reg_we & s.swd);
    endfunction

endpackage

// File: rtl/mux.sv
// Generic 2:1 multiplexer: sel=1 picks b.
module mux #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sel,
    output logic [W-1:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: one outstanding data-memory access with
// ack/timeout handshake, misalign detection and writeback register.
module mem_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_MEM_dmemWe,
    input  logic        i_MEM_regWe,
    input  logic        i_MEM_sWD,
    input  logic [4:0]  i_MEM_WRA,
    input  logic [31:0] i_MEM_ALUout,
    input  logic [31:0] i_MEM_storeData,
    output logic        o_MEM_stall,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_MEM_regWe,
    output logic [4:0]  o_MEM_WRA,
    output logic [31:0] o_MEM_WD,
    output logic        o_MEM_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    stage_t           r;
    stage_t           in_s;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    wb_t              wb;
    wb_t              wb_nxt;
    logic             err_nxt;
    logic             busy;
    logic             ack;
    logic             timeout;
    logic             stall;
    logic             r_access;
    logic             in_go;
    logic [31:0]      mem_wd;

    assign in_s = '{
        dmem_we:    i_MEM_dmemWe,
        reg_we:     i_MEM_regWe,
        swd:        i_MEM_sWD,
        wra:        i_MEM_WRA,
        alu_out:    i_MEM_ALUout,
        store_data: i_MEM_storeData
    };

    assign busy     = (state == BUSY);
    assign ack      = busy & i_dmem_ack;
    assign timeout  = busy & ~i_dmem_ack & (cnt == CNT_LAST);
    assign stall    = busy & ~i_dmem_ack & ~timeout;
    assign r_access = is_access(r);
    assign in_go    = is_access(in_s) & (in_s.alu_out[1:0] == 2'b00);

    mux #(32) u_wd_mux (
        .a   (r.alu_out),
        .b   (i_dmem_rdata),
        .sel (r.swd),
        .y   (mem_wd)
    );

    // BUSY implies R holds an aligned access, so these arms never overlap;
    // the default arm covers both misaligned and timed-out accesses.
    always_comb begin
        wb_nxt  = BUBBLE;
        err_nxt = 1'b0;
        unique case (1'b1)
            stall:     wb_nxt = BUBBLE;
            !r_access: wb_nxt = '{r.reg_we, r.wra, r.alu_out};
            ack:       wb_nxt = '{r.reg_we, r.wra, mem_wd};
            default: begin
                wb_nxt  = '{1'b0, r.wra, 32'h0};
                err_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r         <= '0;
            state     <= IDLE;
            cnt       <= '0;
            wb        <= BUBBLE;
            o_MEM_err <= 1'b0;
        end else begin
            wb        <= wb_nxt;
            o_MEM_err <= err_nxt;
            if (stall) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                r     <= in_s;
                cnt   <= '0;
                state <= in_go ? BUSY : IDLE;
            end
        end
    end

    assign o_MEM_stall  = stall;
    assign o_dmem_req   = busy;
    assign o_dmem_we    = r.dmem_we;
    assign o_dmem_addr  = r.alu_out;
    assign o_dmem_wdata = r.store_data;
    assign o_MEM_regWe  = wb.reg_we;
    assign o_MEM_WRA    = wb.wra;
    assign o_MEM_WD     = wb.wd;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed scenarios then random traffic,
// with a memory responder model and an in-order writeback/error monitor.
module tb_mem_stage;
    import mem_pkg::*;

    localparam int TO = 4;

    logic        clk  = 1'b0;
    logic        rstn = 1'b1;
    logic        ex_dmem_we;
    logic        ex_reg_we;
    logic        ex_swd;
    logic [4:0]  ex_wra;
    logic [31:0] ex_alu;
    logic [31:0] ex_sd;
    logic        stall;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack   = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic        wb_we;
    logic [4:0]  wb_wra;
    logic [31:0] wb_wd;
    logic        err;

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
    } plan_t;

    typedef struct {
        bit          is_err;
        logic [4:0]  wra;
        logic [31:0] wd;
    } ev_t;

    plan_t plan_q[$];
    ev_t   exp_q[$];
    int    last_req_len = 0;
    bit    late = 1'b0;

    mem_stage #(.TIMEOUT(TO)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .i_MEM_dmemWe    (ex_dmem_we),
        .i_MEM_regWe     (ex_reg_we),
        .i_MEM_sWD       (ex_swd),
        .i_MEM_WRA       (ex_wra),
        .i_MEM_ALUout    (ex_alu),
        .i_MEM_storeData (ex_sd),
        .o_MEM_stall     (stall),
        .o_dmem_req      (req),
        .o_dmem_we       (we),
        .o_dmem_addr     (addr),
        .o_dmem_wdata    (wdata),
        .i_dmem_ack      (ack),
        .i_dmem_rdata    (rdata),
        .o_MEM_regWe     (wb_we),
        .o_MEM_WRA       (wb_wra),
        .o_MEM_WD        (wb_wd),
        .o_MEM_err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, want);
        end
    endtask

    task automatic set_nop();
        ex_dmem_we = 1'b0;
        ex_reg_we  = 1'b0;
        ex_swd     = 1'b0;
        ex_wra     = 5'd0;
        ex_alu     = 32'h0;
        ex_sd      = 32'h0;
    endtask

    // Reference model: derive what the instruction must produce, then
    // present it until the stage accepts it. Returns stalled cycles.
    task automatic issue(input bit dw, input bit rw, input bit sw,
                         input logic [4:0] a, input logic [31:0] alu,
                         input logic [31:0] sd, input logic [31:0] rd,
                         input int dly, output int stalls);
        bit   access;
        bit   misal;
        bit   s;
        ev_t  e;
        access = dw | (rw & sw);
        misal  = access && (alu[1:0] != 2'b00);
        if (access && !misal)
            plan_q.push_back('{dw, alu, sd, rd, dly});
        if (access && (misal || dly >= TO)) begin
            e = '{1'b1, a, 32'h0};
            exp_q.push_back(e);
        end else if (rw) begin
            e = '{1'b0, a, (access && sw) ? rd : alu};
            exp_q.push_back(e);
        end
        ex_dmem_we = dw;
        ex_reg_we  = rw;
        ex_swd     = sw;
        ex_wra     = a;
        ex_alu     = alu;
        ex_sd      = sd;
        stalls     = 0;
        forever begin
            @(negedge clk);
            #2;
            s = stall;
            @(posedge clk);
            #1;
            if (!s) break;
            stalls++;
            if (stalls > 50) begin
                tests++;
                fails++;
                $display("FAIL accept_bound: stalled %0d cycles, required < 50",
                         stalls);
                break;
            end
        end
        set_nop();
    endtask

    task automatic nop(output int stalls);
        issue(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 0, stalls);
    endtask

    // Memory responder: acks each request after its planned delay.
    initial begin
        plan_t cur;
        int    c;
        bit    active;
        active = 1'b0;
        c      = 0;
        forever begin
            @(negedge clk);
            ack   = 1'b0;
            rdata = $urandom;
            if (!rstn) begin
                if (active) late = 1'b1;
                active = 1'b0;
            end else if (late && !req) begin
                ack  = 1'b1;
                late = 1'b0;
            end else if (req) begin
                if (!active) begin
                    if (plan_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL spurious_req: addr %h, required no request",
                                 addr);
                    end else begin
                        cur    = plan_q.pop_front();
                        active = 1'b1;
                        c      = 0;
                        chk("req_we", 32'(we), 32'(cur.we));
                        chk("req_addr", addr, cur.addr);
                        chk("req_wdata", wdata, cur.wdata);
                    end
                end else begin
                    chk("req_stable_addr", addr, cur.addr);
                    chk("req_stable_wdata", wdata, cur.wdata);
                end
                if (active) begin
                    if (cur.delay == c) begin
                        ack          = 1'b1;
                        rdata        = cur.rdata;
                        active       = 1'b0;
                        last_req_len = c + 1;
                    end else if (c == TO - 1) begin
                        active       = 1'b0;
                        last_req_len = c + 1;
                    end
                    c++;
                end
            end else if (active) begin
                tests++;
                fails++;
                $display("FAIL req_dropped: req 0 at cycle %0d, required 1", c);
                active = 1'b0;
            end
        end
    end

    // Monitor: every write-back or error must match the next expectation.
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (rstn && (wb_we || err)) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_wb: we %b err %b wra %0d wd %h, required none",
                             wb_we, err, wb_wra, wb_wd);
                end else begin
                    e = exp_q.pop_front();
                    chk("ev_err", 32'(err), 32'(e.is_err));
                    chk("wb_wra", 32'(wb_wra), 32'(e.wra));
                    if (e.is_err) begin
                        chk("err_regwe", 32'(wb_we), 32'd0);
                        chk("err_wd", wb_wd, 32'h0);
                    end else begin
                        chk("wb_wd", wb_wd, e.wd);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        set_nop();
        #1 rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_addr", addr, 32'h0);
        chk("rst_wdata", wdata, 32'h0);
        chk("rst_wb_we", 32'(wb_we), 32'd0);
        chk("rst_wb_wra", 32'(wb_wra), 32'd0);
        chk("rst_wb_wd", wb_wd, 32'h0);
        chk("rst_err", 32'(err), 32'd0);
        rstn = 1'b1;

        // ALU op: result two edges after presentation, no memory traffic
        issue(1'b0, 1'b1, 1'b0, 5'd5, 32'h1234, 32'h0, 32'h0, 0, s);
        @(posedge clk);
        #1;
        chk("alu_wb_we", 32'(wb_we), 32'd1);
        chk("alu_wb_wra", 32'(wb_wra), 32'd5);
        chk("alu_wb_wd", wb_wd, 32'h1234);
        chk("alu_no_req", 32'(req), 32'd0);
        chk("alu_no_stall", 32'(stall), 32'd0);

        // Load acked three cycles after request
        issue(1'b0, 1'b1, 1'b1, 5'd7, 32'h100, 32'h0, 32'hCAFEF00D, 3, s);
        nop(s);
        chk("load_stall_cycles", s, 32'd3);
        chk("load_req_len", last_req_len, 32'd4);
        chk("load_wd", wb_wd, 32'hCAFEF00D);
        chk("load_no_err", 32'(err), 32'd0);

        // Store acked in the request cycle
        issue(1'b1, 1'b0, 1'b0, 5'd9, 32'h40, 32'hA5A5A5A5, 32'h0, 0, s);
        chk("store_req", 32'(req), 32'd1);
        chk("store_we", 32'(we), 32'd1);
        chk("store_addr", addr, 32'h40);
        chk("store_wdata", wdata, 32'hA5A5A5A5);
        nop(s);
        chk("store_stall_cycles", s, 32'd0);
        chk("store_req_len", last_req_len, 32'd1);
        chk("store_wb_we", 32'(wb_we), 32'd0);

        // Load that never acks: timeout after TO request cycles
        issue(1'b0, 1'b1, 1'b1, 5'd3, 32'h200, 32'h0, 32'h0, 99, s);
        nop(s);
        chk("to_stall_cycles", s, 32'(TO - 1));
        chk("to_req_len", last_req_len, 32'(TO));
        chk("to_err", 32'(err), 32'd1);
        chk("to_err_no_req", 32'(req), 32'd0);
        @(posedge clk);
        #1;
        chk("to_err_single", 32'(err), 32'd0);

        // Misaligned load then aligned load back to back
        issue(1'b0, 1'b1, 1'b1, 5'd4, 32'h102, 32'h0, 32'h0, 0, s);
        issue(1'b0, 1'b1, 1'b1, 5'd8, 32'h104, 32'h0, 32'h0BADBEEF, 1, s);
        chk("b2b_req", 32'(req), 32'd1);
        chk("b2b_addr", addr, 32'h104);
        chk("mis_err", 32'(err), 32'd1);
        repeat (3) nop(s);

        // Reset while a load is outstanding; its late ack must be ignored
        issue(1'b0, 1'b1, 1'b1, 5'd6, 32'h300, 32'h0, 32'h5555AAAA, 3, s);
        @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        chk("mid_rst_req", 32'(req), 32'd0);
        chk("mid_rst_stall", 32'(stall), 32'd0);
        chk("mid_rst_wb_we", 32'(wb_we), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("late_ack_no_wb", 32'(wb_we), 32'd0);
            chk("late_ack_no_req", 32'(req), 32'd0);
        end

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            bit          dw;
            bit          rw;
            bit          sw;
            logic [31:0] a;
            dw = ($urandom_range(0, 3) == 0);
            rw = 1'($urandom_range(0, 1));
            sw = 1'($urandom_range(0, 1));
            a  = $urandom & 32'h0000_0FFC;
            if ($urandom_range(0, 7) == 0)
                a[1:0] = 2'($urandom_range(1, 3));
            issue(dw, rw, sw, 5'($urandom_range(0, 31)), a, $urandom,
                  $urandom, $urandom_range(0, TO + 1), s);
        end
        repeat (5) nop(s);
        repeat (3) @(posedge clk);
        #1;
        chk("exp_q_drained", exp_q.size(), 32'd0);
        chk("plan_q_drained", plan_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, maximum BUSY cycles before a memory access is aborted (legal range 1..255).
REQ-002 SHALL have ports:
- clk  in  1  clock, all state on rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- i_MEM_dmemWe  in  1  store instruction from EXE.
- i_MEM_regWe  in  1  register write enable from EXE.
- i_MEM_sWD  in  1  writeback select: 1 = memory read data (load), 0 = ALU result.
- i_MEM_WRA  in  5  destination register.
- i_MEM_ALUout  in  32  ALU result; also the memory address.
- i_MEM_storeData  in  32  store data (forwarded rd2).
- o_MEM_stall  out  1  upstream hold request.
- o_dmem_req  out  1  memory request.
- o_dmem_we  out  1  memory write.
- o_dmem_addr  out  32  memory byte address.
- o_dmem_wdata  out  32  memory write data.
- i_dmem_ack  in  1  memory completion, one-cycle pulse.
- i_dmem_rdata  in  32  read data, valid only in the ack cycle.
- o_MEM_regWe  out  1  to WB.
- o_MEM_WRA  out  5  to WB.
- o_MEM_WD  out  32  to WB.
- o_MEM_err  out  1  one-cycle pulse on misalign or timeout.

Function
REQ-003 SHALL hold a stage register R (dmemWe, regWe, sWD, WRA, ALUout, storeData), loaded from the inputs on every edge where o_MEM_stall=0 and held otherwise.
REQ-004 SHALL classify R: access = R.dmemWe | (R.regWe & R.sWD); misaligned = access & (R.ALUout[1:0] != 0).
REQ-005 SHALL use FSM states IDLE and BUSY.
- IDLE to BUSY on an edge that loads an aligned access into R.
- BUSY to IDLE on the edge of an ack or timeout cycle, unless that same edge loads another aligned access, in which case BUSY is retained.
REQ-006 SHALL drive o_dmem_req = BUSY (registered state only).
- o_dmem_we = R.dmemWe, o_dmem_addr = R.ALUout, o_dmem_wdata = R.storeData.
- These SHALL stay stable while o_dmem_req=1.
REQ-007 SHALL ignore i_dmem_ack when in IDLE.
REQ-008 SHALL keep cycle counter cnt (8 bits): cleared on entry to BUSY, incremented each BUSY cycle without ack.
- Timeout cycle = BUSY & !ack & cnt == TIMEOUT-1.
REQ-009 SHALL drive o_MEM_stall = BUSY & !i_dmem_ack & !timeout (combinational); an ack releases the stall in the same cycle.
REQ-010 SHALL load the WB register {o_MEM_regWe, o_MEM_WRA, o_MEM_WD} on each edge:
- stall=1: bubble {0, 0, 0}.
- non-access: {R.regWe, R.WRA, R.ALUout}.
- ack: {R.regWe, R.WRA, R.sWD ? i_dmem_rdata : R.ALUout}.
- timeout or misaligned: {0, R.WRA, 0}.
REQ-011 SHALL not issue a request for a misaligned access; it retires in one cycle per REQ-010, and o_MEM_err pulses on the following cycle.
REQ-012 SHALL pulse o_MEM_err (registered) for one cycle after a timeout retire; o_dmem_req SHALL be low in that cycle.
REQ-013 SHALL give ack priority when ack and timeout coincide: normal retire, no error.
REQ-014 SHALL have latency: non-access 2 edges input-to-WB; access with ack k cycles after req rises (k>=0) takes 2+k edges.
REQ-015 SHALL retire instructions strictly in order, each exactly once; a bubble SHALL never assert o_MEM_regWe.

Reset
REQ-016 SHALL on rstn=0 immediately clear:
- R, FSM to IDLE, cnt, o_dmem_req, o_MEM_stall, o_MEM_regWe, o_MEM_WRA, o_MEM_WD, o_MEM_err.
- o_dmem_we, o_dmem_addr, o_dmem_wdata to 0.
REQ-017 SHALL abandon an outstanding request if reset occurs in BUSY; an ack arriving after reset release SHALL be ignored.

Structure
REQ-018 SHALL place in shared package mem_pkg: FSM state encoding (IDLE=0, BUSY=1), TIMEOUT default, bubble constant, counter width.
REQ-019 SHALL instantiate the existing 32-bit 2:1 mux sub-module (mux #32) for the writeback data select; all other logic stays in mem_stage.

Verification
REQ-020 SHALL cover an ALU op: regWe=1, sWD=0, WRA=5, ALUout=0x1234 -> o_MEM_regWe=1, WRA=5, WD=0x1234 two edges later; no req, stall=0.
REQ-021 SHALL cover a load: ALUout=0x100, sWD=1, ack with rdata=0xCAFEF00D 3 cycles after req -> stall high 3 cycles, WB WD=0xCAFEF00D, o_MEM_err=0.
REQ-022 SHALL cover a store: dmemWe=1, ALUout=0x40, storeData=0xA5A5A5A5, ack same cycle -> req/we/addr/wdata for exactly 1 cycle, no stall, WB regWe=0.
REQ-023 SHALL cover a timeout: load with TIMEOUT=4 and no ack -> req high 4 cycles, WB regWe=0, o_MEM_err pulses once, next instruction proceeds.
REQ-024 SHALL cover misalign plus back-to-back: load at 0x102 followed by load at 0x104 -> no req for 0x102, err pulse; 0x104 request issued the next cycle.
REQ-025 SHALL cover reset mid-BUSY: rstn low 2 cycles during an outstanding load -> req drops immediately, all outputs 0, a late ack causes no WB write.
